// File: rtl/rtc_set_ctrl.sv
// rtl/rtc_set_ctrl.sv - RTC time-set sequencer: shadow capture, BCD stepping, load strobe
module rtc_set_ctrl #(
   parameter int TIMEOUT_S = 10,
   parameter int TO_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_hrm,
   input  logic [3:0] cur_hrl,
   input  logic [3:0] cur_minm,
   input  logic [3:0] cur_minl,
   output logic       load,
   output logic [3:0] ld_hrm,
   output logic [3:0] ld_hrl,
   output logic [3:0] ld_minm,
   output logic [3:0] ld_minl,
   output logic [3:0] ld_secm,
   output logic [3:0] ld_secl,
   output logic       hold,
   output logic [1:0] set_mode,
   output logic       blink
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10,
      COMMIT  = 2'b11
   } state_t;

   state_t          state;
   logic            mode_prev;
   logic            inc_prev;
   logic [TO_W-1:0] to_cnt;
   logic [3:0]      sh_hrm;
   logic [3:0]      sh_hrl;
   logic [3:0]      sh_minm;
   logic [3:0]      sh_minl;

   logic mode_press;
   logic inc_press;
   logic hr_ok;
   logic min_ok;
   logic timed_out;

   assign mode_press = btn_mode & ~mode_prev;
   assign inc_press  = btn_inc & ~inc_prev;
   assign timed_out  = (to_cnt == TO_W'(TIMEOUT_S));
   assign set_mode   = state;
   assign ld_secm    = 4'd0;
   assign ld_secl    = 4'd0;

   // Captured time must be a legal 00..23 / 00..59 BCD value, else it is zeroed.
   always_comb begin
      hr_ok  = (cur_hrl <= 4'd9) && ((cur_hrm < 4'd2) || ((cur_hrm == 4'd2) && (cur_hrl <= 4'd3)));
      min_ok = (cur_minl <= 4'd9) && (cur_minm <= 4'd5);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         mode_prev <= 1'b1;
         inc_prev  <= 1'b1;
         to_cnt    <= '0;
         sh_hrm    <= 4'd0;
         sh_hrl    <= 4'd0;
         sh_minm   <= 4'd0;
         sh_minl   <= 4'd0;
         ld_hrm    <= 4'd0;
         ld_hrl    <= 4'd0;
         ld_minm   <= 4'd0;
         ld_minl   <= 4'd0;
         load      <= 1'b0;
         hold      <= 1'b0;
         blink     <= 1'b0;
      end else begin
         mode_prev <= btn_mode;
         inc_prev  <= btn_inc;
         load      <= 1'b0;
         case (state)
            RUN: begin
               if (mode_press) begin
                  state   <= SET_HR;
                  hold    <= 1'b1;
                  blink   <= 1'b1;
                  to_cnt  <= '0;
                  sh_hrm  <= hr_ok  ? cur_hrm  : 4'd0;
                  sh_hrl  <= hr_ok  ? cur_hrl  : 4'd0;
                  sh_minm <= min_ok ? cur_minm : 4'd0;
                  sh_minl <= min_ok ? cur_minl : 4'd0;
               end
            end
            SET_HR, SET_MIN: begin
               // Priority: timeout, then MODE, then INC, then tick.
               if (timed_out) begin
                  state  <= RUN;
                  hold   <= 1'b0;
                  blink  <= 1'b0;
                  to_cnt <= '0;
               end else if (mode_press) begin
                  to_cnt <= '0;
                  if (state == SET_HR) begin
                     state <= SET_MIN;
                     blink <= 1'b1;
                  end else begin
                     state   <= COMMIT;
                     blink   <= 1'b0;
                     load    <= 1'b1;
                     ld_hrm  <= sh_hrm;
                     ld_hrl  <= sh_hrl;
                     ld_minm <= sh_minm;
                     ld_minl <= sh_minl;
                  end
               end else if (inc_press) begin
                  to_cnt <= '0;
                  blink  <= 1'b1;
                  if (state == SET_HR) begin
                     if ((sh_hrm == 4'd2) && (sh_hrl == 4'd3)) begin
                        sh_hrm <= 4'd0;
                        sh_hrl <= 4'd0;
                     end else if (sh_hrl == 4'd9) begin
                        sh_hrm <= sh_hrm + 4'd1;
                        sh_hrl <= 4'd0;
                     end else begin
                        sh_hrl <= sh_hrl + 4'd1;
                     end
                  end else begin
                     if (sh_minl == 4'd9) begin
                        sh_minl <= 4'd0;
                        sh_minm <= (sh_minm == 4'd5) ? 4'd0 : sh_minm + 4'd1;
                     end else begin
                        sh_minl <= sh_minl + 4'd1;
                     end
                  end
               end else if (tick) begin
                  to_cnt <= to_cnt + 1'b1;
                  blink  <= ~blink;
               end
            end
            COMMIT: begin
               state <= RUN;
               hold  <= 1'b0;
               blink <= 1'b0;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// tb/tb_rtc_set_ctrl.sv - self-checking bench for rtc_set_ctrl
module tb_rtc_set_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       btn_mode;
   logic       btn_inc;
   logic [3:0] cur_hrm, cur_hrl, cur_minm, cur_minl;
   logic       load;
   logic [3:0] ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl;
   logic       hold;
   logic [1:0] set_mode;
   logic       blink;

   int pass_cnt = 0;
   int total_cnt = 0;
   int load_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (load === 1'b1) load_cnt++;

   rtc_set_ctrl #(.TIMEOUT_S(10), .TO_W(4)) dut (
      .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_hrm(cur_hrm), .cur_hrl(cur_hrl), .cur_minm(cur_minm), .cur_minl(cur_minl),
      .load(load), .ld_hrm(ld_hrm), .ld_hrl(ld_hrl), .ld_minm(ld_minm), .ld_minl(ld_minl),
      .ld_secm(ld_secm), .ld_secl(ld_secl), .hold(hold), .set_mode(set_mode), .blink(blink)
   );

   function automatic logic [23:0] to_bcd(input int h, input int m);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 8'h00};
   endfunction

   // Reference: clamp a captured time to a legal value, as plain integers.
   function automatic int clamp_h(input int tens, input int units);
      return (units <= 9 && tens * 10 + units <= 23) ? tens * 10 + units : 0;
   endfunction

   function automatic int clamp_m(input int tens, input int units);
      return (units <= 9 && tens <= 5) ? tens * 10 + units : 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic m, input logic i);
      btn_mode = m;
      btn_inc  = i;
      step();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step();
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
   endtask

   task automatic set_cur(input int a, input int b, input int c, input int d);
      cur_hrm  = 4'(a);
      cur_hrl  = 4'(b);
      cur_minm = 4'(c);
      cur_minl = 4'(d);
   endtask

   // Full set sequence; returns what was seen at the commit cycle and the cycle after.
   task automatic run_set(input int a, input int b, input int c, input int d,
                          input int nh, input int nm,
                          output logic [23:0] ld_v, output logic [3:0] at_c,
                          output logic [3:0] after_c, output int nload);
      int lc;
      set_cur(a, b, c, d);
      lc = load_cnt;
      press(1'b1, 1'b0);
      repeat (nh) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      repeat (nm) press(1'b0, 1'b1);
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
      ld_v = {ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl};
      at_c = {load, hold, set_mode};
      step();
      after_c = {load, hold, set_mode};
      step();
      nload = load_cnt - lc;
   endtask

   task automatic test_reset();
      tick = 1'b0; btn_inc = 1'b0; btn_mode = 1'b1; rst = 1'b1;
      set_cur(1, 2, 3, 4);
      repeat (3) step();
      rst = 1'b0;
      repeat (3) step();
      total_cnt++;
      if ({load, hold, set_mode, blink} !== 5'b0) begin
         $display("FAIL reset_flags: got %b want 00000", {load, hold, set_mode, blink});
      end else pass_cnt++;
      total_cnt++;
      if ({ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl} !== 24'h0) begin
         $display("FAIL reset_ld: got %h want 000000", {ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl});
      end else pass_cnt++;
      btn_mode = 1'b0;
      step();
   endtask

   task automatic test_set_sequence();
      logic [23:0] ld_v; logic [3:0] at_c, after_c; int nload;
      run_set(1, 2, 3, 4, 3, 27, ld_v, at_c, after_c, nload);
      total_cnt++;
      if (ld_v !== to_bcd(15, 1)) $display("FAIL seq_ld: got %h want %h", ld_v, to_bcd(15, 1));
      else pass_cnt++;
      total_cnt++;
      if (at_c !== 4'b1111) $display("FAIL seq_commit_flags: got %b want 1111", at_c);
      else pass_cnt++;
      total_cnt++;
      if (after_c !== 4'b0000) $display("FAIL seq_after_flags: got %b want 0000", after_c);
      else pass_cnt++;
      total_cnt++;
      if (nload !== 1) $display("FAIL seq_load_count: got %0d want 1", nload);
      else pass_cnt++;
   endtask

   task automatic test_clamp();
      logic [23:0] ld_v; logic [3:0] at_c, after_c; int nload;
      run_set(2, 7, 7, 10, 0, 0, ld_v, at_c, after_c, nload);
      total_cnt++;
      if (ld_v !== to_bcd(0, 0)) $display("FAIL clamp_ld: got %h want %h", ld_v, to_bcd(0, 0));
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [23:0] ld_v; logic [3:0] at_c, after_c; int nload;
      run_set(2, 3, 5, 9, 1, 1, ld_v, at_c, after_c, nload);
      total_cnt++;
      if (ld_v !== to_bcd(0, 0)) $display("FAIL wrap_ld: got %h want %h", ld_v, to_bcd(0, 0));
      else pass_cnt++;
      total_cnt++;
      if (nload !== 1) $display("FAIL wrap_load_count: got %0d want 1", nload);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int lc;
      set_cur(0, 1, 0, 2);
      press(1'b1, 1'b0);
      lc = load_cnt;
      repeat (9) do_tick();
      total_cnt++;
      if ({hold, set_mode, blink} !== 4'b1010) begin
         $display("FAIL timeout_after9: got %b want 1010", {hold, set_mode, blink});
      end else pass_cnt++;
      tick = 1'b1;
      step();
      tick = 1'b0;
      total_cnt++;
      if ({hold, set_mode} !== 3'b101) $display("FAIL timeout_tick10: got %b want 101", {hold, set_mode});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({hold, set_mode, blink} !== 4'b0000) begin
         $display("FAIL timeout_exit: got %b want 0000", {hold, set_mode, blink});
      end else pass_cnt++;
      step();
      total_cnt++;
      if (load_cnt - lc !== 0) $display("FAIL timeout_no_load: got %0d want 0", load_cnt - lc);
      else pass_cnt++;
   endtask

   task automatic test_tick_press();
      set_cur(0, 5, 1, 0);
      press(1'b1, 1'b0);
      repeat (8) do_tick();
      tick = 1'b1;
      btn_inc = 1'b1;
      step();
      tick = 1'b0;
      btn_inc = 1'b0;
      step();
      total_cnt++;
      if ({set_mode, blink} !== 3'b011) $display("FAIL tick_press_blink: got %b want 011", {set_mode, blink});
      else pass_cnt++;
      repeat (9) do_tick();
      total_cnt++;
      if (set_mode !== 2'b01) $display("FAIL tick_press_restart: got %b want 01", set_mode);
      else pass_cnt++;
      do_tick();
      total_cnt++;
      if (set_mode !== 2'b00) $display("FAIL tick_press_timeout: got %b want 00", set_mode);
      else pass_cnt++;
   endtask

   task automatic test_mode_inc();
      set_cur(0, 8, 2, 0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      total_cnt++;
      if (set_mode !== 2'b10) $display("FAIL mode_inc_state: got %b want 10", set_mode);
      else pass_cnt++;
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
      total_cnt++;
      if ({load, ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl} !== {1'b1, to_bcd(8, 20)}) begin
         $display("FAIL mode_inc_ld: got %h want %h",
                  {load, ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl}, {1'b1, to_bcd(8, 20)});
      end else pass_cnt++;
      step();
      step();
   endtask

   task automatic test_rst_commit();
      set_cur(2, 7, 7, 10);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
      total_cnt++;
      if ({load, set_mode} !== 3'b111) $display("FAIL rst_commit_pre: got %b want 111", {load, set_mode});
      else pass_cnt++;
      rst = 1'b1;
      step();
      total_cnt++;
      if ({load, hold, set_mode} !== 4'b0000) begin
         $display("FAIL rst_commit_post: got %b want 0000", {load, hold, set_mode});
      end else pass_cnt++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_random();
      logic [23:0] ld_v; logic [3:0] at_c, after_c; int nload;
      int a, b, c, d, nh, nm, eh, em;
      for (int it = 0; it < 20; it++) begin
         a = int'($urandom_range(0, 3));  b = int'($urandom_range(0, 11));
         c = int'($urandom_range(0, 7));  d = int'($urandom_range(0, 11));
         nh = int'($urandom_range(0, 30)); nm = int'($urandom_range(0, 70));
         eh = (clamp_h(a, b) + nh) % 24;
         em = (clamp_m(c, d) + nm) % 60;
         run_set(a, b, c, d, nh, nm, ld_v, at_c, after_c, nload);
         total_cnt++;
         if (ld_v !== to_bcd(eh, em) || at_c !== 4'b1111 || after_c !== 4'b0000 || nload !== 1) begin
            $display("FAIL random_%0d: got ld=%h at=%b after=%b loads=%0d want ld=%h at=1111 after=0000 loads=1",
                     it, ld_v, at_c, after_c, nload, to_bcd(eh, em));
         end else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_set_sequence();
      test_clamp();
      test_wrap();
      test_timeout();
      test_tick_press();
      test_mode_inc();
      test_rst_commit();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
